recepcao_serial_uc: RTL and testbench

// Receive-side control unit: the counterpart of the pixel/sticker transmit sequencer.

---
 rtl/recepcao_serial_uc.sv | 147 ++++++++++++++
 tb/tb_recepcao_serial_uc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/recepcao_serial_uc.sv
// Receive-side control unit: waits for a header byte, then stores LINHAS x COLUNAS
// payload bytes row-major into the face memory, flagging completion or timeout.
module recepcao_serial_uc #(
  parameter int          LINHAS    = 3,
  parameter int          COLUNAS   = 3,
  parameter int          W_LIN     = 2,
  parameter int          W_COL     = 2,
  parameter logic [7:0]  CABECALHO = 8'hAA,
  parameter int          TIMEOUT   = 50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic             rx_pronto,
  input  logic [7:0]       rx_dado,
  output logic             escreve,
  output logic [W_LIN-1:0] linha,
  output logic [W_COL-1:0] coluna,
  output logic [7:0]       dado_mem,
  output logic             pronto,
  output logic             erro_timeout,
  output logic [3:0]       db_estado
);

  // state     | meaning
  // INICIAL   | idle, waiting for iniciar
  // PREPARA   | clear addresses and timeout counter
  // ESP_CAB   | waiting for the header byte (no timeout)
  // ESP_BYTE  | waiting for a payload byte, timeout running
  // ESCRITA   | memory write pulse
  // CONTA_COL | advance column
  // CONTA_LIN | advance row or finish
  // FINAL     | frame complete pulse
  // ERRO      | timeout pulse
  localparam int W_TO = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    INICIAL   = 4'b0000,
    PREPARA   = 4'b0001,
    ESP_CAB   = 4'b0010,
    ESP_BYTE  = 4'b0011,
    ESCRITA   = 4'b0100,
    CONTA_COL = 4'b0101,
    CONTA_LIN = 4'b0110,
    FINAL     = 4'b0111,
    ERRO      = 4'b1000
  } estado_t;

  estado_t         estado, prox;
  logic [W_TO-1:0] cnt_to;
  logic            fim_col, fim_lin, fim_to;

  assign fim_col = (coluna == W_COL'(COLUNAS - 1));
  assign fim_lin = (linha  == W_LIN'(LINHAS - 1));
  assign fim_to  = (cnt_to == W_TO'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox;
  end

  always_comb begin
    prox         = estado;
    escreve      = 1'b0;
    pronto       = 1'b0;
    erro_timeout = 1'b0;
    db_estado    = 4'b1110;
    case (estado)
      INICIAL: begin
        db_estado = INICIAL;
        if (iniciar) prox = PREPARA;
      end
      PREPARA: begin
        db_estado = PREPARA;
        prox      = ESP_CAB;
      end
      ESP_CAB: begin
        db_estado = ESP_CAB;
        if (rx_pronto && rx_dado == CABECALHO) prox = ESP_BYTE;
      end
      ESP_BYTE: begin
        db_estado = ESP_BYTE;
        // a byte arriving on the last allowed cycle still counts
        if (rx_pronto)   prox = ESCRITA;
        else if (fim_to) prox = ERRO;
      end
      ESCRITA: begin
        db_estado = ESCRITA;
        escreve   = 1'b1;
        prox      = CONTA_COL;
      end
      CONTA_COL: begin
        db_estado = CONTA_COL;
        prox      = fim_col ? CONTA_LIN : ESP_BYTE;
      end
      CONTA_LIN: begin
        db_estado = CONTA_LIN;
        prox      = fim_lin ? FINAL : ESP_BYTE;
      end
      FINAL: begin
        db_estado = FINAL;
        pronto    = 1'b1;
        prox      = INICIAL;
      end
      ERRO: begin
        db_estado    = ERRO;
        erro_timeout = 1'b1;
        prox         = INICIAL;
      end
      default: prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      linha    <= '0;
      coluna   <= '0;
      dado_mem <= '0;
      cnt_to   <= '0;
    end else begin
      case (estado)
        PREPARA: begin
          linha  <= '0;
          coluna <= '0;
          cnt_to <= '0;
        end
        ESP_BYTE: begin
          if (rx_pronto) begin
            dado_mem <= rx_dado;
            cnt_to   <= '0;
          end else begin
            cnt_to <= cnt_to + W_TO'(1);
          end
        end
        CONTA_COL: begin
          if (fim_col) coluna <= '0;
          else         coluna <= coluna + W_COL'(1);
        end
        CONTA_LIN: begin
          if (!fim_lin) linha <= linha + W_LIN'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_recepcao_serial_uc.sv
// Scoreboard bench for recepcao_serial_uc: a 3x3 instance with a short timeout
// and a 1x1 instance, writes checked against a queue of expected (linha,coluna,dado).
module tb_recepcao_serial_uc;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0, rx_pronto = 1'b0;
  logic [7:0] rx_dado = 8'h00;
  logic       escreve, pronto, erro_timeout;
  logic [1:0] linha, coluna;
  logic [7:0] dado_mem;
  logic [3:0] db_estado;

  logic       iniciar1 = 1'b0, rx_pronto1 = 1'b0;
  logic [7:0] rx_dado1 = 8'h00;
  logic       escreve1, pronto1, erro_timeout1;
  logic [0:0] linha1, coluna1;
  logic [7:0] dado_mem1;
  logic [3:0] db_estado1;

  int total = 0, bad = 0;
  int cyc = 0;
  int n_wr = 0, n_pr = 0, n_er = 0, last_wr_cyc = 0, er_cyc = 0;
  int n_wr1 = 0, n_pr1 = 0, n_er1 = 0;
  logic [11:0] q0[$];
  logic [9:0]  q1[$];

  recepcao_serial_uc #(.LINHAS(3), .COLUNAS(3), .W_LIN(2), .W_COL(2),
                       .CABECALHO(8'hAA), .TIMEOUT(20)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .rx_pronto(rx_pronto),
    .rx_dado(rx_dado), .escreve(escreve), .linha(linha), .coluna(coluna),
    .dado_mem(dado_mem), .pronto(pronto), .erro_timeout(erro_timeout),
    .db_estado(db_estado));

  recepcao_serial_uc #(.LINHAS(1), .COLUNAS(1), .W_LIN(1), .W_COL(1),
                       .CABECALHO(8'hAA), .TIMEOUT(20)) dut1 (
    .clock(clock), .reset(reset), .iniciar(iniciar1), .rx_pronto(rx_pronto1),
    .rx_dado(rx_dado1), .escreve(escreve1), .linha(linha1), .coluna(coluna1),
    .dado_mem(dado_mem1), .pronto(pronto1), .erro_timeout(erro_timeout1),
    .db_estado(db_estado1));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (escreve) begin
        n_wr++;
        last_wr_cyc = cyc;
        check("wr_pending", 32'(q0.size() > 0), 1);
        if (q0.size() > 0) check("wr_lcd", {linha, coluna, dado_mem}, q0.pop_front());
      end
      if (pronto) n_pr++;
      if (erro_timeout) begin
        n_er++;
        er_cyc = cyc;
      end
      if (escreve1) begin
        n_wr1++;
        check("wr1_pending", 32'(q1.size() > 0), 1);
        if (q1.size() > 0) check("wr1_lcd", {linha1, coluna1, dado_mem1}, q1.pop_front());
      end
      if (pronto1) n_pr1++;
      if (erro_timeout1) n_er1++;
    end
  end

  task automatic send_byte(input bit sel, input logic [7:0] b);
    @(posedge clock); #1;
    if (sel) begin rx_pronto1 = 1'b1; rx_dado1 = b; end
    else     begin rx_pronto  = 1'b1; rx_dado  = b; end
    @(posedge clock); #1;
    rx_pronto = 1'b0; rx_pronto1 = 1'b0;
    repeat (3) @(posedge clock);
  endtask

  task automatic pulse_iniciar(input bit sel);
    @(posedge clock); #1;
    if (sel) iniciar1 = 1'b1; else iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0; iniciar1 = 1'b0;
  endtask

  // payload indices [first, first+n) of a 3x3 frame, byte value = base + index
  task automatic send_payload(input int first, input int n, input logic [7:0] base);
    for (int i = first; i < first + n; i++) begin
      q0.push_back({2'(i / 3), 2'(i % 3), 8'(base + 8'(i))});
      send_byte(0, 8'(base + 8'(i)));
    end
  endtask

  initial begin
    int wr0, tgt;
    // reset state
    repeat (2) @(posedge clock); #1;
    check("rst_pulses", {escreve, pronto, erro_timeout}, 0);
    check("rst_addr", {linha, coluna, dado_mem}, 0);
    check("rst_state", db_estado, 4'b0000);
    reset = 1'b0;

    // 1: plain 3x3 frame
    pulse_iniciar(0);
    send_byte(0, 8'hAA);
    send_payload(0, 9, 8'h01);
    repeat (10) @(posedge clock); #1;
    check("t1_queue", q0.size(), 0);
    check("t1_writes", n_wr, 9);
    check("t1_pronto", n_pr, 1);
    check("t1_state", db_estado, 4'b0000);

    // 2: junk bytes before the header are discarded
    pulse_iniciar(0);
    send_byte(0, 8'h55);
    send_byte(0, 8'h13);
    check("t2_no_wr", n_wr, 9);
    send_byte(0, 8'hAA);
    send_payload(0, 9, 8'h30);
    repeat (10) @(posedge clock); #1;
    check("t2_queue", q0.size(), 0);
    check("t2_pronto", n_pr, 2);
    check("t2_noerr", n_er, 0);

    // 3: timeout after 4 payload bytes
    wr0 = n_wr;
    pulse_iniciar(0);
    send_byte(0, 8'hAA);
    send_payload(0, 4, 8'h40);
    repeat (40) @(posedge clock); #1;
    check("t3_err", n_er, 1);
    check("t3_err_time", er_cyc - last_wr_cyc, 22);
    check("t3_writes", n_wr - wr0, 4);
    check("t3_no_pronto", n_pr, 2);
    check("t3_state", db_estado, 4'b0000);

    // 4: byte on the last allowed cycle of ESP_BYTE
    pulse_iniciar(0);
    send_byte(0, 8'hAA);
    send_payload(0, 1, 8'h60);
    tgt = last_wr_cyc + 21;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (cyc >= tgt) break;
    end
    check("t4_align", cyc, tgt);
    q0.push_back({2'd0, 2'd1, 8'h22});
    rx_pronto = 1'b1; rx_dado = 8'h22;
    @(posedge clock); #1;
    rx_pronto = 1'b0;
    repeat (3) @(posedge clock);
    check("t4_no_err", n_er, 1);
    send_payload(2, 7, 8'h60);
    repeat (10) @(posedge clock); #1;
    check("t4_queue", q0.size(), 0);
    check("t4_pronto", n_pr, 3);

    // 5: asynchronous reset during the 5th write
    pulse_iniciar(0);
    send_byte(0, 8'hAA);
    send_payload(0, 4, 8'h70);
    @(posedge clock); #1;
    rx_pronto = 1'b1; rx_dado = 8'h75;
    @(posedge clock); #1;
    rx_pronto = 1'b0;
    check("t5_pre_wr", escreve, 1);
    #1 reset = 1'b1;
    #1;
    check("t5_rst_pulses", {escreve, pronto, erro_timeout}, 0);
    check("t5_rst_addr", {linha, coluna, dado_mem}, 0);
    check("t5_rst_state", db_estado, 4'b0000);
    @(posedge clock); #1 reset = 1'b0;
    check("t5_queue", q0.size(), 0);
    pulse_iniciar(0);
    send_byte(0, 8'hAA);
    send_payload(0, 9, 8'h80);
    repeat (10) @(posedge clock); #1;
    check("t5_queue_end", q0.size(), 0);
    check("t5_pronto", n_pr, 4);

    // 6: 1x1 frame, iniciar pulses mid-frame ignored
    pulse_iniciar(1);
    @(posedge clock); #1;
    pulse_iniciar(1);
    check("t6_cab_state", db_estado1, 4'b0010);
    send_byte(1, 8'hAA);
    pulse_iniciar(1);
    check("t6_byte_state", db_estado1, 4'b0011);
    q1.push_back({1'b0, 1'b0, 8'h7F});
    send_byte(1, 8'h7F);
    repeat (10) @(posedge clock); #1;
    check("t6_queue", q1.size(), 0);
    check("t6_writes", n_wr1, 1);
    check("t6_pronto", n_pr1, 1);
    check("t6_noerr", n_er1, 0);
    check("t6_state", db_estado1, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
